clk_en_gen: RTL

Parametrised clock-enable and reset-release generator for the divided design clock domain. Qualifies the clock-wizard lock flag and holds a synchronous downstream reset until lock has been stable for a set time. Then produces NUM_CH independent, runtime-programmable single-cycle clock-enable strobes, used by the fpga core for UART baud ticks, seven-segment scan and LED refresh. Replaces the bare lock-ignoring clocking wrapper.

---
 rtl/clk_en_pkg.sv | 21 ++
 rtl/clk_en_ch.sv | 51 +++++
 rtl/clk_en_gen.sv | 99 +++++++++
 3 files changed

// File: rtl/clk_en_pkg.sv
// ------------------------------------------------------------------
// clk_en_pkg : shared types for the clock-enable / reset generator
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package clk_en_pkg;

   localparam int DIV_W = 16;

   typedef logic [DIV_W-1:0] div_t;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/clk_en_ch.sv
// ------------------------------------------------------------------
// clk_en_ch : one clock-enable channel (shadow divisor, counter, strobe)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module clk_en_ch #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             en,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   input  logic [DIV_W-1:0] div_init,
   output logic             ce
);

   logic [DIV_W-1:0] shadow;
   logic [DIV_W-1:0] cnt;
   logic             at_term;

   // Divisors 0 and 1 both mean "strobe every cycle"
   assign at_term = (shadow <= DIV_W'(1)) || (cnt == shadow - DIV_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= div_init;
         cnt    <= '0;
         ce     <= 1'b0;
      end else begin
         if (load) begin
            shadow <= div;
         end
         if (load || !(run && en)) begin
            cnt <= '0;
            ce  <= 1'b0;
         end else if (at_term) begin
            cnt <= '0;
            ce  <= 1'b1;
         end else begin
            cnt <= cnt + DIV_W'(1);
            ce  <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/clk_en_gen.sv
// ------------------------------------------------------------------
// clk_en_gen : lock-qualified reset release plus NUM_CH clock enables
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module clk_en_gen
   import clk_en_pkg::*;
#(
   parameter int               NUM_CH      = 4,
   parameter int               DIV_W       = clk_en_pkg::DIV_W,
   parameter int               SYNC_STAGES = 2,
   parameter int               HOLD_CYCLES = 16,
   parameter logic [DIV_W-1:0] DIV_INIT    = DIV_W'(1000)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    locked_i,
   input  logic [NUM_CH*DIV_W-1:0] div_i,
   input  logic                    div_load,
   input  logic [NUM_CH-1:0]       ch_en,
   output logic [NUM_CH-1:0]       ce_o,
   output logic                    rst_n_o,
   output logic                    ready
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   lock_s;
   logic [HOLD_W-1:0]      hold_cnt;
   state_t                 state;
   state_t                 next_state;
   logic                   run_next;
   logic                   run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], locked_i};
      end
   end

   assign lock_s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= WAIT_LOCK;
         hold_cnt <= '0;
         rst_n_o  <= 1'b0;
         ready    <= 1'b0;
      end else begin
         state    <= next_state;
         hold_cnt <= (state == HOLD) ? hold_cnt + HOLD_W'(1) : '0;
         rst_n_o  <= run_next;
         ready    <= run_next;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         WAIT_LOCK: if (lock_s) next_state = HOLD;
         HOLD: begin
            if (!lock_s)                                  next_state = WAIT_LOCK;
            else if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) next_state = RUN;
         end
         RUN:       if (!lock_s) next_state = WAIT_LOCK;
         default:   next_state = WAIT_LOCK;
      endcase
   end

   // Channels stop on the cycle lock_s drops so no strobe escapes after rst_n_o falls
   always_comb begin
      run_next = (next_state == RUN);
      run      = (state == RUN) && lock_s;
   end

   generate
      for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
         clk_en_ch #(
            .DIV_W (DIV_W)
         ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (run),
            .en       (ch_en[k]),
            .load     (div_load),
            .div      (div_i[k*DIV_W +: DIV_W]),
            .div_init (DIV_INIT),
            .ce       (ce_o[k])
         );
      end
   endgenerate

endmodule

`default_nettype wire
